// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle and period meter with stuck-input detection and a bit-serial divider.
// Define PWM_METER_GLITCH_FILTER_EN to reject input pulses and gaps shorter than 3 clocks.
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [6:0]       duty_cycle,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  localparam int               DW        = CNT_W + 7;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic             sync1, sync2, s, s_prev;
  logic             rise, fall, timeout;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [DW-1:0]    rem, dvs, diff;
  logic [5:0]       quo;
  logic [2:0]       iter;
  logic             ge;
  logic [6:0]       quo_next;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      s_prev <= s;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[0], sync2};
  end

  // s_prev doubles as the filter's held output: s only moves on three agreeing samples.
  always_comb begin
    // NOTE: assign a default first so no path through the block leaves s unassigned (latch).
    s = s_prev;
    if (sync2 && (&hist))        s = 1'b1;
    else if (!sync2 && !(|hist)) s = 1'b0;
  end
`else
  assign s = sync2;
`endif

  assign rise    = s & ~s_prev;
  assign fall    = ~s & s_prev;
  assign timeout = (state != DIVIDE) && !stuck && (period_cnt >= TIMEOUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (state == IDLE && stuck) begin
      period_cnt <= TIMEOUT_C;
    end else begin
      if (period_cnt != CNT_MAX)    period_cnt <= period_cnt + CNT_W'(1);
      if (s && high_cnt != CNT_MAX) high_cnt   <= high_cnt + CNT_W'(1);
    end
  end

  // Restoring divider: H*100 < 128*P, so seven shifted trial subtractions give the quotient.
  assign ge       = rem >= dvs;
  assign diff     = rem - dvs;
  assign quo_next = {quo, ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      iter       <= '0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            stuck <= 1'b0;
            state <= MEASURE;
          end else if (timeout) begin
            stuck      <= 1'b1;
            period     <= '0;
            duty_cycle <= s ? 7'd100 : 7'd0;
            duty_valid <= 1'b1;
          end else if (stuck && fall) begin
            duty_cycle <= 7'd0;
            duty_valid <= 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            rem   <= DW'(high_cnt) * DW'(100);
            dvs   <= DW'(period_cnt) << 6;
            quo   <= '0;
            iter  <= '0;
            state <= DIVIDE;
          end else if (timeout) begin
            stuck      <= 1'b1;
            period     <= '0;
            duty_cycle <= s ? 7'd100 : 7'd0;
            duty_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        DIVIDE: begin
          if (ge) rem <= diff;
          dvs  <= dvs >> 1;
          quo  <= quo_next[5:0];
          iter <= iter + 3'd1;
          // On the last step dvs has shifted back down to the unscaled period snapshot.
          if (iter == 3'd6) begin
            duty_cycle <= quo_next;
            period     <= dvs[CNT_W-1:0];
            duty_valid <= 1'b1;
            state      <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: a waveform-level model predicts every duty_valid
// (cycle, duty, period, stuck) as stimulus is driven; a negedge monitor pops and compares.
module tb_pwm_duty_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pwm_in = 1'b0;
  logic [6:0]       duty_cycle;
  logic [CNT_W-1:0] period;
  logic             duty_valid;
  logic             stuck;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_cycle (duty_cycle),
    .period     (period),
    .duty_valid (duty_valid),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    int stuck;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state, all in drive-cycle time.
  bit [2:0] hist;
  bit       fv, fv_prev;
  bit       armed, stuck_m;
  int       last_rise, last_meas, hcnt, deadline;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      check("valid_missing", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    if (rst_n === 1'b1 && duty_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("duty_cycle", 32'(duty_cycle), e.duty);
        check("period", 32'(period), e.period);
        check("stuck", 32'(stuck), e.stuck);
      end
    end
  end

  task automatic push(input int duty, input int per, input int stk, input int at);
    exp_t e;
    e.duty = duty; e.period = per; e.stuck = stk; e.cyc = at;
    q.push_back(e);
  endtask

  // Drive one clock of pwm_in and advance the model. A filtered change seen at drive
  // cycle c reaches the meter's edge logic two clocks later in both build variants.
  task automatic drive(input bit v);
    int c;
    @(negedge clk);
    pwm_in  = v;
    c       = cyc;
    hist    = {hist[1:0], v};
    fv_prev = fv;
`ifdef PWM_METER_GLITCH_FILTER_EN
    if (hist == 3'b111)      fv = 1'b1;
    else if (hist == 3'b000) fv = 1'b0;
`else
    fv = v;
`endif
    if (fv && !fv_prev) begin
      if (armed) begin
        if (c - last_meas > 7) begin
          push(hcnt * 100 / (c - last_rise), c - last_rise, 0, c + 10);
          last_meas = c;
        end
      end else begin
        armed     = 1'b1;
        last_meas = -1000;
      end
      stuck_m   = 1'b0;
      last_rise = c;
      hcnt      = 0;
      deadline  = c + 3 + TIMEOUT;
    end else if (fv_prev && !fv && stuck_m) begin
      push(0, 0, 1, c + 3);
    end
    if (fv) hcnt++;
    if (!stuck_m && c == deadline - 3) begin
      push(fv ? 100 : 0, 0, 1, deadline);
      stuck_m = 1'b1;
      armed   = 1'b0;
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic train(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) drive(i < h);
  endtask

  // 25%/100 waveform with a 1-clock high glitch in the middle of each low phase.
  task automatic glitch_train(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 100; i++) drive(i < 25 || i == 60);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("rst_duty_cycle", 32'(duty_cycle), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_duty_valid", 32'(duty_valid), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    q.delete();
    hist = '0; fv = 1'b0; fv_prev = 1'b0;
    armed = 1'b0; stuck_m = 1'b0; hcnt = 0;
    repeat (n) @(negedge clk);
    rst_n     = 1'b1;
    last_rise = cyc;
    last_meas = -1000;
    deadline  = cyc + 1 + TIMEOUT;
  endtask

  initial begin
    int p, h;
    do_reset(3);

    // Input held low from reset: one timeout report with duty 0.
    hold(1'b0, TIMEOUT + 10);

    train(100, 25, 4);
    check("stuck_cleared", 32'(stuck), 32'd0);
    train(97, 33, 4);
    train(10, 9, 3);
    train(13, 3, 3);
    train(50, 47, 3);
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(300, 10);
      h = $urandom_range(p - 3, 3);
      train(p, h, 2);
    end

    // Held high after a measurement, then released: timeout at 100, then a falling-edge report.
    hold(1'b1, TIMEOUT + 100);
    hold(1'b0, 30);
    check("stuck_held", 32'(stuck), 32'd1);
    train(100, 25, 3);

    // Reset in the middle of a division: the pending result must never appear.
    hold(1'b1, 6);
    do_reset(4);
    train(100, 25, 3);

    glitch_train(3);
    hold(1'b0, 30);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
